hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: resolves load-use, branch redirect and cache
// miss stalls into stage-register enables/flushes, tracks a pending I-miss
// across D-miss waits, and counts stall and flush cycles.
module hazard_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       in_IFID_rs1,
  input  logic [4:0]       in_IFID_rs2,
  input  logic [4:0]       in_IDEX_rd,
  input  logic             in_IDEX_mem_read,
  input  logic             in_EX_branch_taken,
  input  logic             in_icache_miss,
  input  logic             in_icache_ready,
  input  logic             in_dcache_miss,
  input  logic             in_dcache_ready,
  output logic             out_PC_write,
  output logic             out_IFID_write,
  output logic             out_IDEX_write,
  output logic             out_EXMEM_write,
  output logic             out_IFID_flush,
  output logic             out_IDEX_flush,
  output logic             out_MEMWB_flush,
  output logic [1:0]       out_state,
  output logic [CNT_W-1:0] out_stall_cycles,
  output logic [CNT_W-1:0] out_flush_count
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StImiss   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       imiss_pending_q, imiss_pending_d;
  logic       load_use, dstall, branch, istall;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Per-cycle hazard conditions, already resolved by priority.
  always_comb begin
    load_use = in_IDEX_mem_read && (in_IDEX_rd != 5'd0) &&
               ((in_IDEX_rd == in_IFID_rs1) || (in_IDEX_rd == in_IFID_rs2));
    dstall   = (((state_q == StRun) || (state_q == StImiss)) && in_dcache_miss) ||
               ((state_q == StMemWait) && !in_dcache_ready);
    branch   = in_EX_branch_taken && !dstall;
    istall   = !dstall && !branch && !load_use &&
               (((state_q == StImiss) && !in_icache_ready) ||
                ((state_q == StRun) && in_icache_miss));
  end

  // Stage enables and bubble insertion; reset forces everything frozen/flushed.
  always_comb begin
    out_PC_write    = 1'b1;
    out_IFID_write  = 1'b1;
    out_IDEX_write  = 1'b1;
    out_EXMEM_write = 1'b1;
    out_IFID_flush  = 1'b0;
    out_IDEX_flush  = 1'b0;
    out_MEMWB_flush = 1'b0;
    if (reset) begin
      out_PC_write    = 1'b0;
      out_IFID_write  = 1'b0;
      out_IDEX_write  = 1'b0;
      out_EXMEM_write = 1'b0;
      out_IFID_flush  = 1'b1;
      out_IDEX_flush  = 1'b1;
      out_MEMWB_flush = 1'b1;
    end else if (dstall) begin
      out_PC_write    = 1'b0;
      out_IFID_write  = 1'b0;
      out_IDEX_write  = 1'b0;
      out_EXMEM_write = 1'b0;
      out_MEMWB_flush = 1'b1;
    end else if (branch) begin
      out_IFID_flush  = 1'b1;
      out_IDEX_flush  = 1'b1;
    end else if (load_use) begin
      out_PC_write    = 1'b0;
      out_IFID_write  = 1'b0;
      out_IDEX_flush  = 1'b1;
    end else if (istall) begin
      out_PC_write    = 1'b0;
      out_IFID_flush  = 1'b1;
    end
  end

  // Next-state and pending I-miss tracking.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (in_dcache_miss)          state_d = StMemWait;
        else if (in_EX_branch_taken) state_d = StRun;
        else if (in_icache_miss)     state_d = StImiss;
      end
      StImiss: begin
        if (in_dcache_miss)                             state_d = StMemWait;
        else if (in_EX_branch_taken || in_icache_ready) state_d = StRun;
      end
      StMemWait: begin
        if (in_dcache_ready) begin
          // A redirect makes any outstanding fetch miss irrelevant.
          if (in_EX_branch_taken)                        state_d = StRun;
          else if (imiss_pending_q && !in_icache_ready)  state_d = StImiss;
          else                                           state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    imiss_pending_d = imiss_pending_q;
    if (in_icache_ready || branch) begin
      imiss_pending_d = 1'b0;
    end else if (in_icache_miss && (state_q != StImiss)) begin
      imiss_pending_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StRun;
      imiss_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      imiss_pending_q <= imiss_pending_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!out_PC_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch && (flush_cnt_q != '1))        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign out_state        = state_q;
  assign out_stall_cycles = stall_cnt_q;
  assign out_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with narrow counters to reach saturation.
module tb_hazard_controller;

  localparam int unsigned CW = 4;
  // {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, MEMWB_flush}
  localparam logic [6:0] C_NONE = 7'b1111_000;
  localparam logic [6:0] C_DST  = 7'b0000_001;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_IST  = 7'b0111_100;
  localparam logic [6:0] C_RST  = 7'b0000_111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1, rs2, rd;
  logic mem_read, br, imiss, iready, dmiss, dready;
  logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f;
  logic [1:0] st;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;
  int checks = 0;
  int failures = 0;

  assign ctl = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f};

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_IFID_rs1(rs1), .in_IFID_rs2(rs2), .in_IDEX_rd(rd), .in_IDEX_mem_read(mem_read),
    .in_EX_branch_taken(br), .in_icache_miss(imiss), .in_icache_ready(iready),
    .in_dcache_miss(dmiss), .in_dcache_ready(dready),
    .out_PC_write(pc_w), .out_IFID_write(ifid_w), .out_IDEX_write(idex_w),
    .out_EXMEM_write(exmem_w), .out_IFID_flush(ifid_f), .out_IDEX_flush(idex_f),
    .out_MEMWB_flush(memwb_f), .out_state(st), .out_stall_cycles(stall_cnt),
    .out_flush_count(flush_cnt)
  );

  task automatic clear_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; mem_read = 1'b0; br = 1'b0;
    imiss = 1'b0; iready = 1'b0; dmiss = 1'b0; dready = 1'b0;
  endtask

  // Inputs change 1 time unit after posedge; checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
    checks++;
    if (st !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++; $display("FAIL reset_state st=%0d stall=%0d flush=%0d exp=0/0/0", st, stall_cnt, flush_cnt);
    end
    checks++;
    tick();
    tick();
    reset = 1'b0;
    #2;
    if (ctl !== C_NONE || st !== 2'd0) begin
      failures++; $display("FAIL reset_release ctl=%b st=%0d exp=%b/0", ctl, st, C_NONE);
    end
    checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    rd = 5'd5; mem_read = 1'b1; rs1 = 5'd3; rs2 = 5'd5;
    #2;
    if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
    checks++;
    tick();
    clear_inputs();
    #2;
    if (ctl !== C_NONE || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL lu_after ctl=%b stall=%0d exp=%b/1", ctl, stall_cnt, C_NONE);
    end
    checks++;
    rd = 5'd0; mem_read = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    #2;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, C_NONE); end
    checks++;
    rd = 5'd9; rs1 = 5'd9; rs2 = 5'd1;
    #2;
    if (ctl !== C_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
    checks++;
    mem_read = 1'b0;
    #2;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lu_noload got=%b exp=%b", ctl, C_NONE); end
    checks++;
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    rd = 5'd7; mem_read = 1'b1; rs1 = 5'd7; br = 1'b1;
    #2;
    if (ctl !== C_BR || flush_cnt !== 4'd0) begin
      failures++; $display("FAIL br_lu ctl=%b flush=%0d exp=%b/0", ctl, flush_cnt, C_BR);
    end
    checks++;
    tick();
    clear_inputs();
    #2;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0 || st !== 2'd0) begin
      failures++; $display("FAIL br_cnt flush=%0d stall=%0d st=%0d exp=1/0/0", flush_cnt, stall_cnt, st);
    end
    checks++;
  endtask

  task automatic test_dcache_miss();
    do_reset();
    dmiss = 1'b1;
    #2;
    if (ctl !== C_DST || st !== 2'd0) begin
      failures++; $display("FAIL dm_c0 ctl=%b st=%0d exp=%b/0", ctl, st, C_DST);
    end
    checks++;
    tick();
    dmiss = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #2;
      if (ctl !== C_DST || st !== 2'd2) begin
        failures++; $display("FAIL dm_wait%0d ctl=%b st=%0d exp=%b/2", i, ctl, st, C_DST);
      end
      checks++;
      tick();
    end
    dready = 1'b1; br = 1'b1;
    #2;
    // Ready cycle is not a stall, so a simultaneous branch takes effect.
    if (ctl !== C_BR || st !== 2'd2) begin
      failures++; $display("FAIL dm_ready ctl=%b st=%0d exp=%b/2", ctl, st, C_BR);
    end
    checks++;
    tick();
    clear_inputs();
    #2;
    if (st !== 2'd0 || stall_cnt !== 4'd4 || ctl !== C_NONE) begin
      failures++; $display("FAIL dm_done st=%0d stall=%0d ctl=%b exp=0/4/%b", st, stall_cnt, ctl, C_NONE);
    end
    checks++;
  endtask

  task automatic test_imiss_dmiss(input bit with_ready);
    logic [1:0] exp_st;
    exp_st = with_ready ? 2'd0 : 2'd1;
    do_reset();
    imiss = 1'b1;
    #2;
    if (ctl !== C_IST || st !== 2'd0) begin
      failures++; $display("FAIL id_imiss ctl=%b st=%0d exp=%b/0", ctl, st, C_IST);
    end
    checks++;
    tick();
    imiss = 1'b0; dmiss = 1'b1;
    #2;
    if (ctl !== C_DST || st !== 2'd1) begin
      failures++; $display("FAIL id_dmiss ctl=%b st=%0d exp=%b/1", ctl, st, C_DST);
    end
    checks++;
    tick();
    dmiss = 1'b0; iready = with_ready;
    tick();
    iready = 1'b0; dready = 1'b1;
    #2;
    if (ctl !== C_NONE || st !== 2'd2) begin
      failures++; $display("FAIL id_dready ctl=%b st=%0d exp=%b/2", ctl, st, C_NONE);
    end
    checks++;
    tick();
    dready = 1'b0;
    #2;
    if (st !== exp_st) begin
      failures++; $display("FAIL id_final_r%0d st=%0d exp=%0d", with_ready, st, exp_st);
    end
    checks++;
  endtask

  task automatic test_branch_in_imiss();
    do_reset();
    imiss = 1'b1;
    tick();
    imiss = 1'b0; br = 1'b1;
    #2;
    if (ctl !== C_BR || st !== 2'd1) begin
      failures++; $display("FAIL bi_redirect ctl=%b st=%0d exp=%b/1", ctl, st, C_BR);
    end
    checks++;
    tick();
    br = 1'b0;
    #2;
    if (st !== 2'd0 || ctl !== C_NONE || flush_cnt !== 4'd1) begin
      failures++; $display("FAIL bi_run st=%0d ctl=%b flush=%0d exp=0/%b/1", st, ctl, flush_cnt, C_NONE);
    end
    checks++;
    // A cleared pending miss means the D-miss wait ends in RUN, not IMISS.
    dmiss = 1'b1;
    tick();
    dmiss = 1'b0; dready = 1'b1;
    tick();
    dready = 1'b0;
    #2;
    if (st !== 2'd0) begin failures++; $display("FAIL bi_pending st=%0d exp=0", st); end
    checks++;
  endtask

  task automatic test_imiss_ready_same_cycle();
    do_reset();
    imiss = 1'b1; iready = 1'b1;
    tick();
    imiss = 1'b0; iready = 1'b0;
    #2;
    if (st !== 2'd1) begin failures++; $display("FAIL sc_state st=%0d exp=1", st); end
    checks++;
    dmiss = 1'b1;
    tick();
    dmiss = 1'b0; dready = 1'b1;
    tick();
    dready = 1'b0;
    #2;
    if (st !== 2'd0) begin failures++; $display("FAIL sc_pending st=%0d exp=0", st); end
    checks++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmiss = 1'b1;
    tick();
    dmiss = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    if (ctl !== C_RST || st !== 2'd0 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL rm_async ctl=%b st=%0d stall=%0d exp=%b/0/0", ctl, st, stall_cnt, C_RST);
    end
    checks++;
    tick();
    reset = 1'b0;
    #2;
    if (ctl !== C_NONE || st !== 2'd0) begin
      failures++; $display("FAIL rm_release ctl=%b st=%0d exp=%b/0", ctl, st, C_NONE);
    end
    checks++;
    tick();
    #2;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || st !== 2'd0) begin
      failures++; $display("FAIL rm_counters stall=%0d flush=%0d st=%0d exp=0/0/0", stall_cnt, flush_cnt, st);
    end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    dmiss = 1'b1;
    tick();
    dmiss = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    #2;
    if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
    checks++;
    dready = 1'b1;
    tick();
    dready = 1'b0;
    #2;
    if (stall_cnt !== 4'd15 || st !== 2'd0) begin
      failures++; $display("FAIL sat_hold stall=%0d st=%0d exp=15/0", stall_cnt, st);
    end
    checks++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_dcache_miss();
    test_imiss_dmiss(1'b1);
    test_imiss_dmiss(1'b0);
    test_branch_in_imiss();
    test_imiss_ready_same_cycle();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
